// File: rtl/wb_commit_trace_pkg.sv
// Shared pipeline-debug definitions: commit field widths, the commit record and
// a saturating increment used by the trace counters.
package wb_commit_trace_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } commit_t;

    // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is visible on dout while level != 0.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_commit_trace.sv
// Writeback commit tracer: time-stamps register-file commits into a FWFT FIFO
// and counts dropped commits and hazard stall cycles. Never stalls the pipeline.
module wb_commit_trace
    import wb_commit_trace_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int STAMP_W = 16,
    parameter int DROP_W  = 8,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               w_reg_wr_en,
    input  logic [REG_W-1:0]   w_reg_write,
    input  logic [DATA_W-1:0]  w_write_data,
    input  logic               ishazard,
    input  logic               trace_en,
    input  logic               clr,
    output logic               trace_valid,
    input  logic               trace_ready,
    output logic [REG_W-1:0]   trace_reg,
    output logic [DATA_W-1:0]  trace_data,
    output logic [STAMP_W-1:0] trace_stamp,
    output logic [LVL_W-1:0]   level,
    output logic               overflow,
    output logic [DROP_W-1:0]  drop_count,
    output logic [15:0]        stall_count
);

    localparam int ENTRY_W = REG_W + DATA_W + STAMP_W;

    logic [STAMP_W-1:0] cyc_cnt;
    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;
    commit_t            head_commit;
    logic [STAMP_W-1:0] head_stamp;
    logic               push_req;
    logic               pop;
    logic               drop;
    logic               full;
    logic               empty;

    assign push_req = trace_en & w_reg_wr_en & (w_reg_write != '0) & ~clr;
    assign pop      = trace_valid & trace_ready;
    assign drop     = push_req & full & ~pop;
    assign fifo_din = {w_reg_write, w_write_data, cyc_cnt};

    sync_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push_req),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // Storage is not reset; masking with valid keeps the head at zero when empty.
    assign trace_valid                = ~empty;
    assign {head_commit, head_stamp}  = trace_valid ? fifo_dout : '0;
    assign trace_reg                  = head_commit.rd;
    assign trace_data                 = head_commit.data;
    assign trace_stamp                = head_stamp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt     <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
            stall_count <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + STAMP_W'(1);
            if (clr) begin
                overflow    <= 1'b0;
                drop_count  <= '0;
                stall_count <= '0;
            end else begin
                if (drop) begin
                    overflow   <= 1'b1;
                    drop_count <= DROP_W'(sat_inc(32'(drop_count), DROP_W));
                end
                if (ishazard) stall_count <= 16'(sat_inc(32'(stall_count), 16));
            end
        end
    end

endmodule

// File: tb/tb_wb_commit_trace.sv
// Bench for wb_commit_trace: table-driven vectors plus hand sequences, checked
// against a scoreboard queue and an independent counter model.
module tb_wb_commit_trace;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        w_reg_wr_en;
    logic [4:0]  w_reg_write;
    logic [31:0] w_write_data;
    logic        ishazard;
    logic        trace_en;
    logic        clr;
    logic        trace_valid;
    logic        trace_ready;
    logic [4:0]  trace_reg;
    logic [31:0] trace_data;
    logic [15:0] trace_stamp;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [15:0] stall_count;

    wb_commit_trace #(.DEPTH(DEPTH), .STAMP_W(16), .DROP_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .w_reg_wr_en  (w_reg_wr_en),
        .w_reg_write  (w_reg_write),
        .w_write_data (w_write_data),
        .ishazard     (ishazard),
        .trace_en     (trace_en),
        .clr          (clr),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_reg    (trace_reg),
        .trace_data   (trace_data),
        .trace_stamp  (trace_stamp),
        .level        (level),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [15:0] stamp;
    } ent_t;

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        haz;
        logic        en;
        logic        cl;
        logic        rdy;
        int          exp_level;
    } vec_t;

    ent_t        sb_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          cyc_m  = 0;
    logic [7:0]  m_drop = '0;
    logic [15:0] m_stall = '0;
    logic        m_ovf = 1'b0;
    vec_t        tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [4:0] rd, input logic [31:0] data,
                         input logic haz, input logic en, input logic cl, input logic rdy);
        w_reg_wr_en  = wr;
        w_reg_write  = rd;
        w_write_data = data;
        ishazard     = haz;
        trace_en     = en;
        clr          = cl;
        trace_ready  = rdy;
    endtask

    // Check the head, update the model for the coming edge, clock, check state.
    task automatic step();
        ent_t dummy;
        chk("valid", trace_valid, 64'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            chk("head_reg",   trace_reg,   sb_q[0].rd);
            chk("head_data",  trace_data,  sb_q[0].data);
            chk("head_stamp", trace_stamp, sb_q[0].stamp);
        end
        if (clr) begin
            sb_q.delete();
            m_drop  = '0;
            m_stall = '0;
            m_ovf   = 1'b0;
        end else begin
            if (sb_q.size() != 0 && trace_ready) dummy = sb_q.pop_front();
            if (trace_en && w_reg_wr_en && w_reg_write != 5'd0) begin
                if (sb_q.size() < DEPTH) begin
                    sb_q.push_back('{w_reg_write, w_write_data, cyc_m[15:0]});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 8'hFF) m_drop++;
                end
            end
            if (ishazard && m_stall != 16'hFFFF) m_stall++;
        end
        cyc_m++;
        @(posedge clk);
        #1;
        chk("level",       level,       64'(sb_q.size()));
        chk("overflow",    overflow,    m_ovf);
        chk("drop_count",  drop_count,  m_drop);
        chk("stall_count", stall_count, m_stall);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[4]  = '{1'b1, 5'd8,  32'h11,       1'b0, 1'b1, 1'b0, 1'b1, 1};
        tbl[5]  = '{1'b1, 5'd9,  32'h22,       1'b0, 1'b1, 1'b0, 1'b1, 1};
        tbl[6]  = '{1'b1, 5'd10, 32'h33,       1'b0, 1'b1, 1'b0, 1'b1, 1};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[8]  = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[9]  = '{1'b0, 5'd5,  32'h5,        1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 0};

        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #2 rst = 1'b0;
        #10;
        chk("rst_valid",    trace_valid, 0);
        chk("rst_level",    level,       0);
        chk("rst_reg",      trace_reg,   0);
        chk("rst_data",     trace_data,  0);
        chk("rst_stamp",    trace_stamp, 0);
        chk("rst_overflow", overflow,    0);
        chk("rst_drop",     drop_count,  0);
        chk("rst_stall",    stall_count, 0);
        @(negedge clk);
        rst   = 1'b1;
        cyc_m = 0;

        // Commits at cycles 4..6 with ready high, then r0 and disabled writes
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].wr, tbl[i].rd, tbl[i].data, tbl[i].haz, tbl[i].en, tbl[i].cl, tbl[i].rdy);
            step();
            chk("tbl_level", level, 64'(tbl[i].exp_level));
        end
        chk("tbl_overflow", overflow, 0);

        // Ten commits with no consumer: two dropped
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b0);
            step();
        end
        chk("full_level", level,      8);
        chk("full_drop",  drop_count, 2);
        chk("full_ovf",   overflow,   1);

        // Push and pop on a full FIFO
        drive(1'b1, 5'd12, 32'h55, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        chk("pp_level", level,      8);
        chk("pp_drop",  drop_count, 2);

        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step();
        chk("last_reg",  trace_reg,  12);
        chk("last_data", trace_data, 32'h55);
        step();
        chk("drain_level", level, 0);

        // Hazard stalls, then clr with entries queued
        for (int i = 0; i < 5; i++) begin
            drive(i < 3, 5'(20 + i), 32'hA0 + 32'(i), 1'b1, 1'b1, 1'b0, 1'b0);
            step();
        end
        chk("stall5", stall_count, 5);
        chk("pre_clr_level", level, 3);
        drive(1'b1, 5'd7, 32'h7, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        chk("clr_level", level,       0);
        chk("clr_stall", stall_count, 0);
        chk("clr_valid", trace_valid, 0);
        chk("clr_ovf",   overflow,    0);
        drive(1'b1, 5'd21, 32'h77, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        step();

        // Asynchronous reset with 4 entries queued
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(16 + i), 32'hC0 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b0);
            step();
        end
        chk("pre_rst_level", level, 4);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", trace_valid, 0);
        chk("arst_level", level,       0);
        chk("arst_reg",   trace_reg,   0);
        sb_q.delete();
        m_drop  = '0;
        m_stall = '0;
        m_ovf   = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
        cyc_m = 0;
        drive(1'b1, 5'd3, 32'h99, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("restart_stamp", trace_stamp, 0);
        chk("restart_reg",   trace_reg,   3);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
